// File: rtl/axi_lite_sram_pkg.sv
// Shared definitions for the AXI4-lite SRAM slave: FSM state encoding, response codes, base address.
// Optional feature macro used by this slice: SRAM_RAND_DELAY_EN.
package axi_lite_sram_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RD_WAIT    = 3'd1,
        RD_RESP    = 3'd2,
        WR_COLLECT = 3'd3,
        WR_WAIT    = 3'd4,
        WR_RESP    = 3'd5
    } sram_state_e;

    localparam logic [1:0]  RESP_OKAY      = 2'b00;
    localparam logic [1:0]  RESP_DECERR    = 2'b11;
    localparam logic [31:0] SRAM_BASE_ADDR = 32'h8000_0000;
    localparam logic [7:0]  LFSR_SEED      = 8'hA5;

    function automatic logic [1:0] respFor(input logic inRange);
        return inRange ? RESP_OKAY : RESP_DECERR;
    endfunction

endpackage

// File: rtl/axi_lite_sram_if.sv
// AXI4-lite style channel bundle between the IFU/LSU arbiter (master) and the SRAM (slave).
// Used by axi_lite_sram; no configuration macros.
interface axi_lite_sram_if;

    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic [3:0]  rid;
    logic        rlast;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;

    modport master (
        output arvalid, araddr, arid, rready,
        output awvalid, awaddr, wvalid, wdata, wstrb, bready,
        input  arready, rvalid, rdata, rresp, rid, rlast,
        input  awready, wready, bvalid, bresp
    );

    modport slave (
        input  arvalid, araddr, arid, rready,
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready,
        output arready, rvalid, rdata, rresp, rid, rlast,
        output awready, wready, bvalid, bresp
    );

endinterface

// File: rtl/axi_lite_sram_lat_lfsr.sv
// sram_lat_lfsr: free-running 8-bit LFSR that adds 0..7 random cycles to a base latency.
// Only instantiated when SRAM_RAND_DELAY_EN is defined.
module sram_lat_lfsr
    import axi_lite_sram_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] lat_i,
    output logic [4:0] delay_o
);

    logic [7:0] lfsr_q;

    // Fibonacci form, taps 8,6,5,4 (bits 7,5,4,3), shifting towards the MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    assign delay_o = {1'b0, lat_i} + {2'b00, lfsr_q[2:0]};

endmodule

// File: rtl/axi_lite_sram.sv
// Single-port AXI4-lite SRAM slave, one outstanding transaction, programmable read/write latency.
// Define SRAM_RAND_DELAY_EN to add 0..7 pseudo-random cycles to each transaction's latency.
module axi_lite_sram
    import axi_lite_sram_pkg::*;
#(
    parameter int          MEM_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR = SRAM_BASE_ADDR,
    parameter int          RD_LAT    = 1,
    parameter int          WR_LAT    = 1
) (
    input  logic           clk,
    input  logic           rst,
    axi_lite_sram_if.slave bus
);

    localparam int          IDX_W = $clog2(MEM_WORDS);
    localparam logic [31:0] SPAN  = 32'(4 * MEM_WORDS);

    sram_state_e state_q;
    logic [4:0]  cnt_q;
    logic        acc_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [3:0]  arid_q;
    logic        awGot_q;
    logic        wGot_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;
    logic [3:0]  rid_q;
    logic [1:0]  bresp_q;

    logic [31:0] mem [MEM_WORDS];
    logic [31:0] memRd_q;

    logic [31:0]      offset;
    logic             inRange;
    logic [IDX_W-1:0] idx;
    logic             isIdle;
    logic             isCollect;
    logic             awFire;
    logic             wFire;
    logic             arFire;
    logic             wrBoth;
    logic             memWe;
    logic [3:0]       baseLat;
    logic [4:0]       loadLat;

    // Addresses below BASE_ADDR wrap to huge offsets, so one unsigned compare covers both bounds.
    assign offset  = addr_q - BASE_ADDR;
    assign inRange = offset < SPAN;
    assign idx     = offset[IDX_W+1:2];

    assign isIdle    = state_q == IDLE;
    assign isCollect = state_q == WR_COLLECT;

    assign bus.awready = !rst && (isIdle || (isCollect && !awGot_q));
    assign bus.wready  = !rst && (isIdle || (isCollect && !wGot_q));
    assign bus.arready = !rst && isIdle && !bus.awvalid && !bus.wvalid;

    assign awFire = bus.awvalid && bus.awready;
    assign wFire  = bus.wvalid && bus.wready;
    assign arFire = bus.arvalid && bus.arready;
    assign wrBoth = (awGot_q || awFire) && (wGot_q || wFire);

    assign baseLat = (isIdle && !awFire && !wFire) ? 4'(RD_LAT) : 4'(WR_LAT);

`ifdef SRAM_RAND_DELAY_EN
    sram_lat_lfsr u_lat_lfsr (
        .clk     (clk),
        .rst     (rst),
        .lat_i   (baseLat),
        .delay_o (loadLat)
    );
`else
    assign loadLat = {1'b0, baseLat};
`endif

    assign memWe = !rst && (state_q == WR_WAIT) && (cnt_q == 5'd0) && !acc_q && inRange;

    // Synchronous-read array; the registered read word is consumed one cycle after count 0.
    always_ff @(posedge clk) begin
        if (memWe) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_q[b]) begin
                    mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
        memRd_q <= mem[idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            arid_q  <= '0;
            awGot_q <= 1'b0;
            wGot_q  <= 1'b0;
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
            rid_q   <= '0;
            bresp_q <= RESP_OKAY;
        end else begin
            case (state_q)
                IDLE, WR_COLLECT: begin
                    if (awFire) begin
                        addr_q  <= bus.awaddr;
                        awGot_q <= 1'b1;
                    end
                    if (wFire) begin
                        wdata_q <= bus.wdata;
                        wstrb_q <= bus.wstrb;
                        wGot_q  <= 1'b1;
                    end
                    if (awFire || wFire) begin
                        if (wrBoth) begin
                            awGot_q <= 1'b0;
                            wGot_q  <= 1'b0;
                            cnt_q   <= loadLat;
                            state_q <= WR_WAIT;
                        end else begin
                            state_q <= WR_COLLECT;
                        end
                    end else if (arFire) begin
                        addr_q  <= bus.araddr;
                        arid_q  <= bus.arid;
                        cnt_q   <= loadLat;
                        state_q <= RD_WAIT;
                    end
                end
                // First count-0 cycle performs the array access, the next one registers the response.
                RD_WAIT: begin
                    if (acc_q) begin
                        acc_q   <= 1'b0;
                        rdata_q <= inRange ? memRd_q : 32'd0;
                        rresp_q <= respFor(inRange);
                        rid_q   <= arid_q;
                        state_q <= RD_RESP;
                    end else if (cnt_q != 5'd0) begin
                        cnt_q <= cnt_q - 5'd1;
                    end else begin
                        acc_q <= 1'b1;
                    end
                end
                RD_RESP: begin
                    if (bus.rready) begin
                        state_q <= IDLE;
                    end
                end
                WR_WAIT: begin
                    if (acc_q) begin
                        acc_q   <= 1'b0;
                        bresp_q <= respFor(inRange);
                        state_q <= WR_RESP;
                    end else if (cnt_q != 5'd0) begin
                        cnt_q <= cnt_q - 5'd1;
                    end else begin
                        acc_q <= 1'b1;
                    end
                end
                WR_RESP: begin
                    if (bus.bready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.rvalid = state_q == RD_RESP;
    assign bus.rlast  = state_q == RD_RESP;
    assign bus.rdata  = rdata_q;
    assign bus.rresp  = rresp_q;
    assign bus.rid    = rid_q;
    assign bus.bvalid = state_q == WR_RESP;
    assign bus.bresp  = bresp_q;

endmodule
